pll_drp_reconfig: RTL

Runtime reconfiguration controller for the core clock PLL (PLLE2 CLKOUT0 divider) through its DRP port, driven from the 100 MHz board clock domain.
- Accepts a new CLKOUT0 divide value and holds the PLL in reset while it read-modify-writes ClkReg1/ClkReg2.
- Releases the PLL, waits for a stable lock, then releases the downstream core reset.
- Lets the SERV core array be re-clocked without reloading the bitstream.

---
 rtl/pll_drp_reconfig.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig: runtime CLKOUT0 divide change over the PLLE2 DRP.
// Holds the PLL in reset across the RMW, then gates core reset on stable lock.
module pll_drp_reconfig #(
  parameter int         DRP_TIMEOUT  = 64,
  parameter int         LOCK_STABLE  = 16,
  parameter int         LOCK_TIMEOUT = 65536,
  parameter logic [6:0] CLKREG1_ADDR = 7'h08,
  parameter logic [6:0] CLKREG2_ADDR = 7'h09
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [6:0]  i_divide,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [6:0]  o_daddr,
  output logic        o_den,
  output logic        o_dwe,
  output logic [15:0] o_di,
  input  logic [15:0] i_do,
  input  logic        i_drdy,
  input  logic        i_locked,
  output logic        o_pll_rst,
  output logic        o_rst
);

  localparam int DW = $clog2(DRP_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_IDLE, S_PLL_RST, S_RD1,
    S_WR1, S_RD2, S_WR2, S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    div_q, div_d;
  logic          rst_q, rst_d;
  logic          pll_rst_q, pll_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          den_q, den_d;
  logic          dwe_q, dwe_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [15:0]   di_q, di_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] to_q, to_d;
  logic          fired_q, fired_d;
  logic [DW-1:0] drp_q, drp_d;
  logic          reconf_q, reconf_d;
  logic          lock_meta_q, lock_q;

  logic [5:0] hi, lo;
  logic       req_ok, legal;
  logic       unused_do;

  // Split the divide into high/low counter times for ClkReg1
  assign hi = div_q[6:1];
  assign lo = 6'(div_q - {1'b0, div_q[6:1]});
  assign unused_do = ^i_do[7:6];

  assign req_ok = i_req & ((state_q == S_IDLE) |
                  ((state_q == S_WAIT_LOCK) & fired_q));
  assign legal  = (i_divide >= 7'd2) && (i_divide <= 7'd126);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    rst_d     = rst_q;
    pll_rst_d = pll_rst_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    den_d     = 1'b0;
    dwe_d     = 1'b0;
    daddr_d   = daddr_q;
    di_d      = di_q;
    stab_d    = '0;
    to_d      = to_q;
    fired_d   = fired_q;
    drp_d     = '0;
    reconf_d  = reconf_q;
    unique case (state_q)
      S_WAIT_LOCK: begin
        if (!fired_q) begin
          if (to_q == TW'(LOCK_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            fired_d = 1'b1;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        if (lock_q) begin
          stab_d = stab_q + 1'b1;
          if (stab_d == SW'(LOCK_STABLE)) begin
            state_d  = S_IDLE;
            rst_d    = 1'b0;
            done_d   = reconf_q;
            reconf_d = 1'b0;
          end
        end
      end
      S_IDLE: begin
        if (!lock_q) begin
          state_d  = S_WAIT_LOCK;
          rst_d    = 1'b1;
          to_d     = '0;
          fired_d  = 1'b0;
          reconf_d = 1'b0;
        end
      end
      S_PLL_RST: begin
        state_d = S_RD1;
        den_d   = 1'b1;
        daddr_d = CLKREG1_ADDR;
      end
      S_RD1, S_WR1, S_RD2, S_WR2: begin
        drp_d = drp_q + 1'b1;
        if (i_drdy) begin
          drp_d = '0;
          den_d = 1'b1;
          unique case (state_q)
            S_RD1: begin
              state_d = S_WR1;
              dwe_d   = 1'b1;
              di_d    = {i_do[15:12], hi, lo};
            end
            S_WR1: begin
              state_d = S_RD2;
              daddr_d = CLKREG2_ADDR;
            end
            S_RD2: begin
              state_d = S_WR2;
              dwe_d   = 1'b1;
              di_d    = {i_do[15:8], div_q[0], 1'b0, i_do[5:0]};
            end
            default: begin
              state_d   = S_RELEASE;
              den_d     = 1'b0;
              pll_rst_d = 1'b0;
              reconf_d  = 1'b1;
            end
          endcase
        end else if (drp_q == DW'(DRP_TIMEOUT - 1)) begin
          state_d   = S_RELEASE;
          err_d     = 1'b1;
          pll_rst_d = 1'b0;
          reconf_d  = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_WAIT_LOCK;
        to_d    = '0;
        fired_d = 1'b0;
      end
    endcase
    if (req_ok) begin
      div_d = i_divide;
      if (legal) begin
        state_d   = S_PLL_RST;
        pll_rst_d = 1'b1;
        rst_d     = 1'b1;
        done_d    = 1'b0;
        stab_d    = '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State, lock synchronizer and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_WAIT_LOCK;
      div_q       <= '0;
      rst_q       <= 1'b1;
      pll_rst_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      stab_q      <= '0;
      to_q        <= '0;
      fired_q     <= 1'b0;
      drp_q       <= '0;
      reconf_q    <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      rst_q       <= rst_d;
      pll_rst_q   <= pll_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      stab_q      <= stab_d;
      to_q        <= to_d;
      fired_q     <= fired_d;
      drp_q       <= drp_d;
      reconf_q    <= reconf_d;
      lock_meta_q <= i_locked;
      lock_q      <= lock_meta_q;
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_daddr   = daddr_q;
  assign o_den     = den_q;
  assign o_dwe     = dwe_q;
  assign o_di      = di_q;
  assign o_pll_rst = pll_rst_q;
  assign o_rst     = rst_q;

endmodule
